// File: rtl/result_collector.sv
// result_collector: captures one solver result per rising edge of the
// completed level into a first-word-fall-through FIFO, and keeps saturating
// counts of dropped captures and of completions that reported overflow.
module result_collector #(
   parameter int DEPTH = 8,
   parameter int CNT_W = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [15:0]              result,
   input  logic                     zero,
   input  logic                     overflow,
   input  logic                     completed,
   input  logic                     rd_en,
   output logic [17:0]              rd_data,
   output logic                     empty,
   output logic                     full,
   output logic [$clog2(DEPTH):0]   level,
   output logic [CNT_W-1:0]         drop_cnt,
   output logic [CNT_W-1:0]         ovf_cnt
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] LVL_FULL = (AW+1)'(DEPTH);
   localparam logic [AW:0] LVL_ZERO = '0;

   // Saturating increment: holds at all-ones instead of wrapping.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                               input logic en);
      if (en && (v != {CNT_W{1'b1}})) begin
         return v + CNT_W'(1);
      end
      return v;
   endfunction

   logic              completed_q, completed_d;
   logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [AW:0]       level_q, level_d;
   logic [CNT_W-1:0]  drop_q, drop_d;
   logic [CNT_W-1:0]  ovf_q, ovf_d;
   logic [17:0]       rd_data_q, rd_data_d;
   logic [17:0]       mem_q [DEPTH];

   logic              capture;
   logic              is_empty;
   logic              is_full;
   logic              pop;
   logic              push;
   logic              drop;
   logic [17:0]       wr_entry;

   // Next-state logic: edge detect, push/pop arbitration, pointers, level,
   // counters, and the prefetched head word for the fall-through output.
   always_comb begin
      capture     = completed & ~completed_q;
      is_empty    = (level_q == LVL_ZERO);
      is_full     = (level_q == LVL_FULL);
      // A pop on a full FIFO frees the slot the simultaneous capture needs.
      pop         = rd_en & ~is_empty;
      push        = capture & (~is_full | pop);
      drop        = capture & is_full & ~pop;
      wr_entry    = {overflow, zero, result};

      completed_d = completed;
      rd_ptr_d    = rd_ptr_q;
      wr_ptr_d    = wr_ptr_q;
      level_d     = level_q;
      drop_d      = sat_inc(drop_q, drop);
      // Overflow completions are counted whether or not they were stored.
      ovf_d       = sat_inc(ovf_q, capture & overflow);
      rd_data_d   = rd_data_q;

      if (push) begin
         wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end

      case ({push, pop})
         2'b10:   level_d = level_q + (AW+1)'(1);
         2'b01:   level_d = level_q - (AW+1)'(1);
         default: level_d = level_q;
      endcase

      // rd_data is a register loaded with the next head; when that head is
      // the slot being written this same cycle, bypass the incoming word.
      // With nothing left to show, the last value is held.
      if (level_d != LVL_ZERO) begin
         if (push && (wr_ptr_q == rd_ptr_d)) begin
            rd_data_d = wr_entry;
         end else begin
            rd_data_d = mem_q[rd_ptr_d];
         end
      end
   end

   // Control and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         completed_q <= 1'b1;
         rd_ptr_q    <= '0;
         wr_ptr_q    <= '0;
         level_q     <= '0;
         drop_q      <= '0;
         ovf_q       <= '0;
         rd_data_q   <= '0;
      end else begin
         completed_q <= completed_d;
         rd_ptr_q    <= rd_ptr_d;
         wr_ptr_q    <= wr_ptr_d;
         level_q     <= level_d;
         drop_q      <= drop_d;
         ovf_q       <= ovf_d;
         rd_data_q   <= rd_data_d;
      end
   end

   // Storage array; contents are don't-care after reset, so no reset here.
   always_ff @(posedge clk) begin
      if (!rst && push) begin
         mem_q[wr_ptr_q] <= wr_entry;
      end
   end

   assign rd_data  = rd_data_q;
   assign empty    = (level_q == LVL_ZERO);
   assign full     = (level_q == LVL_FULL);
   assign level    = level_q;
   assign drop_cnt = drop_q;
   assign ovf_cnt  = ovf_q;

endmodule

// File: tb/tb_result_collector.sv
// Directed bench for result_collector (DEPTH=8, CNT_W=8).
module tb_result_collector;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] result;
   logic        zero;
   logic        overflow;
   logic        completed;
   logic        rd_en;
   logic [17:0] rd_data;
   logic        empty;
   logic        full;
   logic [3:0]  level;
   logic [7:0]  drop_cnt;
   logic [7:0]  ovf_cnt;

   int errors = 0;
   int checks = 0;

   result_collector #(.DEPTH(8), .CNT_W(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .result    (result),
      .zero      (zero),
      .overflow  (overflow),
      .completed (completed),
      .rd_en     (rd_en),
      .rd_data   (rd_data),
      .empty     (empty),
      .full      (full),
      .level     (level),
      .drop_cnt  (drop_cnt),
      .ovf_cnt   (ovf_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One completion pulse: high for one cycle, then low for one cycle.
   task automatic pulse(input logic [15:0] res, input logic ovf, input logic z);
      result    = res;
      overflow  = ovf;
      zero      = z;
      completed = 1'b1;
      step();
      completed = 1'b0;
      step();
   endtask

   // Check the head word, then pop it.
   task automatic pop_check(input string tag, input logic [17:0] exp);
      check(tag, 32'(rd_data), 32'(exp));
      rd_en = 1'b1;
      step();
      rd_en = 1'b0;
   endtask

   initial begin
      rst = 1'b1; result = '0; zero = 1'b0; overflow = 1'b0;
      completed = 1'b0; rd_en = 1'b0;
      step();
      step();
      check("rst_empty", 32'(empty), 32'd1);
      check("rst_full", 32'(full), 32'd0);
      check("rst_level", 32'(level), 32'd0);
      check("rst_drop", 32'(drop_cnt), 32'd0);
      check("rst_ovf", 32'(ovf_cnt), 32'd0);
      check("rst_rd_data", 32'(rd_data), 32'd0);
      rst = 1'b0;
      step();

      // Single capture, one-cycle latency
      result = 16'h0061; completed = 1'b1;
      step();
      check("cap_empty", 32'(empty), 32'd0);
      check("cap_rd_data", 32'(rd_data), 32'h00061);
      check("cap_level", 32'(level), 32'd1);
      completed = 1'b0;
      step();
      rd_en = 1'b1;
      step();
      rd_en = 1'b0;
      check("pop_empty", 32'(empty), 32'd1);
      check("hold_rd_data", 32'(rd_data), 32'h00061);
      rd_en = 1'b1;
      step();
      rd_en = 1'b0;
      check("pop_on_empty_level", 32'(level), 32'd0);

      // Level held high for 10 cycles -> one entry
      result = 16'h0005; completed = 1'b1;
      for (int i = 0; i < 10; i++) step();
      completed = 1'b0;
      step();
      check("held_level", 32'(level), 32'd1);
      check("held_rd_data", 32'(rd_data), 32'h00005);
      pop_check("held_pop", 18'h00005);
      check("held_empty", 32'(empty), 32'd1);

      // Nine pulses into DEPTH=8 -> full, one drop
      for (int i = 1; i <= 9; i++) pulse(16'(i), 1'b0, 1'b0);
      check("fill_full", 32'(full), 32'd1);
      check("fill_level", 32'(level), 32'd8);
      check("fill_drop", 32'(drop_cnt), 32'd1);
      check("fill_head", 32'(rd_data), 32'h00001);

      // Full: capture and pop together
      result = 16'h00AA; completed = 1'b1; rd_en = 1'b1;
      step();
      completed = 1'b0; rd_en = 1'b0;
      check("fullrw_level", 32'(level), 32'd8);
      check("fullrw_drop", 32'(drop_cnt), 32'd1);
      check("fullrw_full", 32'(full), 32'd1);
      step();
      for (int i = 2; i <= 8; i++) pop_check($sformatf("order_%0d", i), 18'(i));
      pop_check("order_aa", 18'h000AA);
      check("drain_empty", 32'(empty), 32'd0 + 32'd1);

      // Capture while empty with rd_en high: pop ignored
      result = 16'h0033; completed = 1'b1; rd_en = 1'b1;
      step();
      check("emptyrw_level", 32'(level), 32'd1);
      check("emptyrw_rd_data", 32'(rd_data), 32'h00033);
      completed = 1'b0; rd_en = 1'b0;
      step();

      // Level 1: capture and pop together, new head bypassed
      result = 16'h0044; completed = 1'b1; rd_en = 1'b1;
      step();
      completed = 1'b0; rd_en = 1'b0;
      check("midrw_level", 32'(level), 32'd1);
      check("midrw_rd_data", 32'(rd_data), 32'h00044);
      step();
      pop_check("midrw_pop", 18'h00044);

      // Zero flag packing
      pulse(16'h0000, 1'b0, 1'b1);
      pop_check("zero_flag", 18'h10000);

      // Overflow flag packing and counter
      pulse(16'hFFFF, 1'b1, 1'b0);
      check("ovf_rd_data", 32'(rd_data), 32'h2FFFF);
      check("ovf_cnt_1", 32'(ovf_cnt), 32'd1);
      pop_check("ovf_pop", 18'h2FFFF);
      for (int i = 0; i < 299; i++) pulse(16'hFFFF, 1'b1, 1'b0);
      check("ovf_sat", 32'(ovf_cnt), 32'd255);
      check("drop_sat", 32'(drop_cnt), 32'd255);
      check("sat_level", 32'(level), 32'd8);

      // Reset with level 5 while completed rises
      for (int i = 0; i < 3; i++) pop_check($sformatf("pre_rst_%0d", i), 18'h2FFFF);
      check("pre_rst_level", 32'(level), 32'd5);
      rst = 1'b1; completed = 1'b1; result = 16'h0077; rd_en = 1'b1;
      step();
      rd_en = 1'b0;
      check("rst2_level", 32'(level), 32'd0);
      check("rst2_empty", 32'(empty), 32'd1);
      check("rst2_drop", 32'(drop_cnt), 32'd0);
      check("rst2_ovf", 32'(ovf_cnt), 32'd0);
      check("rst2_rd_data", 32'(rd_data), 32'd0);
      rst = 1'b0;
      step();
      check("post_rst_high_empty", 32'(empty), 32'd1);
      completed = 1'b0;
      step();
      pulse(16'h0123, 1'b0, 1'b0);
      check("post_rst_cap", 32'(rd_data), 32'h00123);
      check("post_rst_level", 32'(level), 32'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
